mx_accum_drain: RTL and testbench
=================================

Name: mx_accum_drain

Overview:
- Downstream end of the MX MAC accumulator path.
- Paces one accumulation tile of K multiply steps into the MAC, waits for the accumulator register to settle, and snapshots {sign, exp, mant}.
- Normalises and rounds the snapshot into an IEEE-754 binary32 word, then emits it over a valid/ready stream.
- Pulses a clear back to the accumulator so the next tile starts from zero.

Parameters:
- M_out_width, 16, accumulator mantissa width (8..32).
- FRAC_BITS, M_out_width-1, number of fractional bits in acc_mant_i.

Ports:
- clk_i  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; loads cfg_k_steps and begins a tile (honoured only in IDLE)
- cfg_k_steps  in  16  number of MAC steps per tile
- step_valid  in  1  upstream operand pair valid (same meaning as A_valid&B_valid at the MAC)
- step_ready  out  1  high when a step may be issued to the MAC
- acc_mant_i  in  M_out_width  accumulator mantissa, unsigned magnitude
- acc_exp_i  in  8  accumulator exponent, bias 127
- acc_sign_i  in  1  accumulator sign
- acc_clear_o  out  1  one-cycle clear request to the accumulator
- out_valid  out  1  result valid
- out_ready  in  1  downstream ready
- out_data  out  32  binary32 result
- out_flags  out  3  {inexact, overflow, zero_or_flush}
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: state IDLE, internal counter 0, and every output 0 (step_ready, acc_clear_o, out_valid, out_data, out_flags, busy).
- Reset asserted mid-tile aborts the tile immediately; no partial result is emitted.
- Accumulator value is (-1)^s * mant * 2^(exp-127-FRAC_BITS).
- States: IDLE -> ACCUM -> CAPTURE -> CONV -> SEND.
- IDLE:
  - start with cfg_k_steps != 0: cnt <= cfg_k_steps, go to ACCUM.
  - start with cfg_k_steps == 0: ignored, stay in IDLE.
- ACCUM:
  - step_ready = 1.
  - Each edge with step_valid & step_ready decrements cnt.
  - When the accepted step has cnt == 1, go to CAPTURE; step_ready drops from that cycle.
- CAPTURE:
  - step_ready = 0.
  - On the exiting edge, acc_* is registered into the snapshot; the MAC result from the last step is valid here.
  - Go to CONV.
- CONV:
  - acc_clear_o = 1 for exactly this cycle.
  - Conversion is computed combinationally from the snapshot and registered into out_data/out_flags on the exiting edge.
  - Go to SEND.
- SEND:
  - out_valid = 1; out_data and out_flags are held stable until out_valid & out_ready.
  - On that handshake: out_valid = 0 next cycle.
  - If start is high in the same cycle with cfg_k_steps != 0, go to ACCUM directly; otherwise go to IDLE.
  - start in any other non-IDLE cycle is ignored.
- Latency: last step accepted at edge E0 -> out_valid high after E0+2 edges. Minimum tile turnaround is K+3 cycles.
- Conversion:
  - mant == 0: out_data = {s, 31'b0}, flags = 3'b001.
  - Otherwise let p = index of the leading one. Biased exponent E = exp - FRAC_BITS + p, computed signed at 11 bits.
  - p <= 23: fraction = bits below p, left-aligned to 23 bits, exact.
  - p > 23: round to nearest even on the discarded bits; inexact = 1 if any discarded bit is 1. A rounding carry out of the fraction increments E.
  - E <= 0: flush to {s, 31'b0}, flags zero_or_flush = 1 (inexact = 1 as well).
  - E >= 255 (after rounding): {s, 8'hFF, 23'b0}, overflow = 1.
  - Otherwise: {s, E[7:0], frac}.
- Simultaneous step_valid in CAPTURE, CONV or SEND is not accepted (step_ready = 0), so the MAC never updates during drain.

Test Plan:
- Reset then start with K=3; three steps, the middle one with step_valid low for 2 cycles; MAC state sign=0, exp=127, mant=0x8000 -> exactly 3 steps accepted, acc_clear_o pulses once, out_data=0x3F800000, flags=000, out_valid 2 edges after the 3rd accept.
- K=1; snapshot sign=1, exp=127, mant=0x0001 -> out_data=0xB8000000, flags=000.
- K=1; mant=0x0000 with sign=1 -> 0x80000000, flags=001. Separately exp=10, mant=0x0001, sign=0 -> 0x00000000, flags=101.
- K=1; exp=255, mant=0x8000, sign=1 -> 0xFF800000, flags=010.
- Backpressure: out_ready held low 5 cycles in SEND -> out_data/out_flags stable, step_ready=0, start pulses ignored. Then out_ready high together with start and K=2 -> direct SEND->ACCUM, busy stays 1.
- rstn pulsed low mid-ACCUM (cnt=2) -> all outputs 0, state IDLE, no out_valid. Also start with K=0 -> no state change.

Source files
------------

// File: rtl/mx_accum_drain.sv
// mx_accum_drain: paces one MAC tile, snapshots the accumulator, converts it to binary32 and streams it out
// Ports: clk_i/rstn clock and async active-low reset; start/cfg_k_steps launch a tile of K steps;
// step_valid/step_ready pace MAC steps; acc_mant_i/acc_exp_i/acc_sign_i accumulator value;
// acc_clear_o one-cycle accumulator clear; out_valid/out_ready/out_data/out_flags result stream
// ({inexact, overflow, zero_or_flush}); busy high outside IDLE.
module mx_accum_drain #(
  parameter int M_out_width = 16,
  parameter int FRAC_BITS = M_out_width - 1
) (
  input  logic                   clk_i,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [15:0]            cfg_k_steps,
  input  logic                   step_valid,
  output logic                   step_ready,
  input  logic [M_out_width-1:0] acc_mant_i,
  input  logic [7:0]             acc_exp_i,
  input  logic                   acc_sign_i,
  output logic                   acc_clear_o,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_data,
  output logic [2:0]             out_flags,
  output logic                   busy
);
  localparam int W = M_out_width;
  typedef enum logic [2:0] {IDLE, ACCUM, CAPTURE, CONV, SEND} state_t;
  state_t state, state_n;
  logic [15:0] cnt, cnt_n;
  logic launch;
  logic [W-1:0] snap_mant;
  logic [7:0] snap_exp;
  logic snap_sign;
  logic [5:0] lead, sh;
  logic [W-1:0] norm;
  logic [W+22:0] ext;
  logic guard, sticky, inexact;
  logic [23:0] rnd;
  logic signed [10:0] e_pre, e_fin;
  logic [31:0] conv_data;
  logic [2:0] conv_flags;
  assign launch = start && (cfg_k_steps != 16'd0);
  assign step_ready = state == ACCUM;
  assign acc_clear_o = state == CONV;
  assign out_valid = state == SEND;
  assign busy = state != IDLE;
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (launch) begin
        state_n = ACCUM;
        cnt_n = cfg_k_steps;
      end
      ACCUM: if (step_valid) begin
        cnt_n = cnt - 16'd1;
        state_n = (cnt == 16'd1) ? CAPTURE : ACCUM;
      end
      CAPTURE: state_n = CONV;
      CONV: state_n = SEND;
      SEND: if (out_ready) begin
        state_n = launch ? ACCUM : IDLE;
        cnt_n = launch ? cfg_k_steps : cnt;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      snap_mant <= '0;
      snap_exp <= '0;
      snap_sign <= 1'b0;
      out_data <= '0;
      out_flags <= '0;
    end else begin
      if (state == CAPTURE) begin
        snap_mant <= acc_mant_i;
        snap_exp <= acc_exp_i;
        snap_sign <= acc_sign_i;
      end
      if (state == CONV) begin
        out_data <= conv_data;
        out_flags <= conv_flags;
      end
    end
  end
  // Shifting by W-lead drops the leading one, leaving the fraction left-aligned;
  // the top 23 bits of ext are the kept fraction, the rest feed guard/sticky.
  always_comb begin
    lead = '0;
    for (int i = 0; i < W; i++) lead = snap_mant[i] ? 6'(i) : lead;
    sh = 6'(W) - lead;
    norm = snap_mant << sh;
    ext = {norm, 23'b0};
    guard = ext[W-1];
    sticky = |ext[W-2:0];
    inexact = guard | sticky;
    rnd = {1'b0, ext[W+22:W]} + 24'(guard & (sticky | ext[W]));
    e_pre = 11'(snap_exp) - 11'(FRAC_BITS) + 11'(lead);
    e_fin = e_pre + 11'(rnd[23]);
    conv_data = (snap_mant == '0 || e_pre <= 11'sd0) ? {snap_sign, 31'b0} :
                (e_fin >= 11'sd255) ? {snap_sign, 8'hFF, 23'b0} : {snap_sign, e_fin[7:0], rnd[22:0]};
    conv_flags = (snap_mant == '0) ? 3'b001 :
                 (e_pre <= 11'sd0) ? 3'b101 :
                 (e_fin >= 11'sd255) ? {inexact, 2'b10} : {inexact, 2'b00};
  end
endmodule

// File: tb/tb_mx_accum_drain.sv
// tb_mx_accum_drain: directed scoreboard bench for mx_accum_drain
module tb_mx_accum_drain;
  logic clk_i = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic [15:0] cfg_k_steps = '0;
  logic step_valid = 1'b0;
  logic step_ready;
  logic [15:0] acc_mant_i = '0;
  logic [7:0] acc_exp_i = '0;
  logic acc_sign_i = 1'b0;
  logic acc_clear_o;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [31:0] out_data;
  logic [2:0] out_flags;
  logic busy;
  int checks = 0, errors = 0;
  int accepts = 0, clears = 0, valids = 0, cyc = 0, last_acc = 0, lat = -1;
  int a0, v0, n;
  logic pv = 1'b0;
  logic [34:0] sb[$];

  always #5 clk_i = ~clk_i;

  mx_accum_drain dut (
    .clk_i(clk_i), .rstn(rstn), .start(start), .cfg_k_steps(cfg_k_steps),
    .step_valid(step_valid), .step_ready(step_ready), .acc_mant_i(acc_mant_i),
    .acc_exp_i(acc_exp_i), .acc_sign_i(acc_sign_i), .acc_clear_o(acc_clear_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  always @(negedge clk_i) begin
    if (step_valid && step_ready) begin
      accepts++;
      last_acc = cyc;
    end
    if (acc_clear_o) clears++;
    if (out_valid && !pv) begin
      lat = cyc - last_acc;
      valids++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected: observed %h expected no output", {out_data, out_flags});
      end else chk("sb_result", {out_data, out_flags}, sb.pop_front());
    end
    pv = out_valid;
    cyc++;
  end

  task automatic tile(input logic [15:0] k, input logic s, input logic [7:0] e, input logic [15:0] m,
                      input logic [31:0] xd, input logic [2:0] xf, input int gap);
    int ta, tc, tn;
    sb.push_back({xd, xf});
    acc_sign_i = s;
    acc_exp_i = e;
    acc_mant_i = m;
    ta = accepts;
    tc = clears;
    start = 1'b1;
    cfg_k_steps = k;
    tick();
    start = 1'b0;
    chk("busy_start", busy, 1);
    for (int i = 0; i < k; i++) begin
      step_valid = 1'b1;
      tick();
      if (i == 0 && gap > 0) begin
        step_valid = 1'b0;
        repeat (gap) tick();
      end
    end
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    tn = 0;
    while (busy && tn < 20) begin
      tick();
      tn++;
    end
    chk("tile_done", busy, 0);
    chk("accepts", accepts - ta, k);
    chk("clears", clears - tc, 1);
    chk("latency", lat, 3);
    chk("sb_empty", sb.size(), 0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_step_ready", step_ready, 0);
    chk("rst_clear", acc_clear_o, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_flags", out_flags, 0);
    rstn = 1'b1;
    tick();
    tile(16'd3, 1'b0, 8'd127, 16'h8000, 32'h3F800000, 3'b000, 2);
    tile(16'd1, 1'b1, 8'd127, 16'h0001, 32'hB8000000, 3'b000, 0);
    tile(16'd1, 1'b1, 8'd100, 16'h0000, 32'h80000000, 3'b001, 0);
    tile(16'd1, 1'b0, 8'd10, 16'h0001, 32'h00000000, 3'b101, 0);
    tile(16'd1, 1'b1, 8'd255, 16'h8000, 32'hFF800000, 3'b010, 0);
    tile(16'd2, 1'b0, 8'd130, 16'hC000, 32'h41400000, 3'b000, 0);
    sb.push_back({32'h40000000, 3'b000});
    acc_sign_i = 1'b0;
    acc_exp_i = 8'd128;
    acc_mant_i = 16'h8000;
    out_ready = 1'b0;
    start = 1'b1;
    cfg_k_steps = 16'd1;
    tick();
    start = 1'b0;
    step_valid = 1'b1;
    tick();
    step_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("bp_valid", out_valid, 1);
    a0 = accepts;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      cfg_k_steps = 16'd5;
      step_valid = 1'b1;
      tick();
      chk("bp_data", out_data, 32'h40000000);
      chk("bp_flags", out_flags, 3'b000);
      chk("bp_step_ready", step_ready, 0);
      chk("bp_hold", out_valid, 1);
    end
    start = 1'b0;
    step_valid = 1'b0;
    chk("bp_no_accept", accepts - a0, 0);
    sb.push_back({32'h3F800000, 3'b000});
    acc_exp_i = 8'd127;
    out_ready = 1'b1;
    start = 1'b1;
    cfg_k_steps = 16'd2;
    tick();
    start = 1'b0;
    chk("direct_busy", busy, 1);
    chk("direct_step_ready", step_ready, 1);
    chk("direct_valid", out_valid, 0);
    step_valid = 1'b1;
    repeat (2) tick();
    step_valid = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    chk("direct_accepts", accepts - a0, 2);
    chk("direct_sb_empty", sb.size(), 0);
    v0 = valids;
    a0 = accepts;
    start = 1'b1;
    cfg_k_steps = 16'd4;
    tick();
    start = 1'b0;
    step_valid = 1'b1;
    repeat (2) tick();
    step_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_step_ready", step_ready, 0);
    chk("mid_rst_clear", acc_clear_o, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_flags", out_flags, 0);
    tick();
    rstn = 1'b1;
    step_valid = 1'b1;
    repeat (3) tick();
    step_valid = 1'b0;
    repeat (5) tick();
    chk("abort_no_valid", valids - v0, 0);
    chk("abort_accepts", accepts - a0, 2);
    chk("abort_idle", busy, 0);
    start = 1'b1;
    cfg_k_steps = 16'd0;
    tick();
    start = 1'b0;
    chk("k0_busy", busy, 0);
    chk("k0_step_ready", step_ready, 0);
    tick();
    chk("k0_still_idle", busy, 0);
    chk("final_sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end
endmodule
